dice_roll_scheduler: RTL and testbench

//  Shares one 4-bit LFSR random generator between two players and sequences each roll.

---
 rtl/dice_pkg.sv | 13 +
 rtl/step_timer.sv | 33 +++
 rtl/dice_roll_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dice_roll_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice roll scheduler.
package dice_pkg;

    localparam int NPLAYER = 2;
    localparam int RAND_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_SPIN, S_LATCH, S_HOLD} state_t;

    function automatic logic [NPLAYER-1:0] player_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; expire pulses for one cycle when an armed count reaches zero.
module step_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic             armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            count_q <= load_val;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (count_q == '0) begin
                armed_q <= 1'b0;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign expire = armed_q && (count_q == '0);

endmodule

// File: rtl/dice_roll_scheduler.sv
// Round-robin arbiter and roll sequencer sharing one RNG between two players.
// Define DICE_QUEUE_EN to remember requests that arrive while busy or lose arbitration.
module dice_roll_scheduler
    import dice_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000 / 16,
    parameter int unsigned FAST_STEPS  = 13,
    parameter int unsigned SLOW_STEPS  = 5,
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NPLAYER-1:0] i_req,
    input  logic [RAND_W-1:0] i_rand,
    output logic              o_step,
    output logic [NPLAYER-1:0] o_grant,
    output logic              o_busy,
    output logic              o_done,
    output logic [RAND_W-1:0] o_result0,
    output logic [RAND_W-1:0] o_result1
);

    localparam int unsigned TOTAL_STEPS = FAST_STEPS + SLOW_STEPS;
    localparam int unsigned IVL_W       = $clog2(TICK_DIV) + SLOW_STEPS + 1;
    localparam int unsigned HOLD_W      = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TMR_W       = (IVL_W > HOLD_W) ? IVL_W : HOLD_W;
    localparam int unsigned CNT_W       = $clog2(TOTAL_STEPS + 1);

    localparam logic [IVL_W-1:0] TICK_INIT = IVL_W'(TICK_DIV);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(TOTAL_STEPS);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_STEPS);

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               rr_q, rr_d;
    logic               spin_first_q, spin_first_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [IVL_W-1:0]   interval_q, interval_d;
    logic [RAND_W-1:0]  result0_q, result1_q;

    logic [NPLAYER-1:0] cand;
    logic               grant_player;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expire;

    step_timer #(
        .WIDTH(TMR_W)
    ) u_step_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

`ifdef DICE_QUEUE_EN
    logic [NPLAYER-1:0] pending_q, pending_d;

    // Queued players outrank fresh requests so nobody is starved by a faster presser.
    assign cand = (pending_q != '0) ? pending_q : i_req;

    always_comb begin
        pending_d = pending_q;
        if (state_q == S_IDLE) begin
            if (cand != '0) begin
                pending_d = (pending_q | i_req) & ~player_onehot(grant_player);
            end
        end else begin
            pending_d = pending_q | (i_req & ~player_onehot(owner_q));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    assign cand = i_req;
`endif

    assign grant_player = (cand == 2'b11) ? rr_q : cand[1];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        spin_first_d = 1'b0;
        step_cnt_d   = step_cnt_q;
        interval_d   = interval_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        o_step       = 1'b0;
        o_done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cand != '0) begin
                    owner_d      = grant_player;
                    rr_d         = ~grant_player;
                    step_cnt_d   = '0;
                    interval_d   = TICK_INIT;
                    spin_first_d = 1'b1;
                    state_d      = S_SPIN;
                end
            end
            S_SPIN: begin
                if (spin_first_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(interval_q - 1'b1);
                end else if (tmr_expire) begin
                    o_step     = 1'b1;
                    step_cnt_d = step_cnt_q + 1'b1;
                    if (step_cnt_d == LAST_STEP) begin
                        state_d = S_LATCH;
                    end else begin
                        // Slow-down phase: the gap before every step past FAST_STEPS doubles.
                        if (step_cnt_d >= FAST_LAST) begin
                            interval_d = interval_q << 1;
                        end
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(interval_d - 1'b1);
                    end
                end
            end
            S_LATCH: begin
                o_done   = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LOAD;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (tmr_expire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            spin_first_q <= 1'b0;
            step_cnt_q   <= '0;
            interval_q   <= '0;
            result0_q    <= '0;
            result1_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            spin_first_q <= spin_first_d;
            step_cnt_q   <= step_cnt_d;
            interval_q   <= interval_d;
            if (state_q == S_LATCH) begin
                if (owner_q) begin
                    result1_q <= i_rand;
                end else begin
                    result0_q <= i_rand;
                end
            end
        end
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_grant   = o_busy ? player_onehot(owner_q) : '0;
    assign o_result0 = result0_q;
    assign o_result1 = result1_q;

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Randomized self-checking bench for dice_roll_scheduler with a roll-level reference model.
module tb_dice_roll_scheduler;

    localparam int TD    = 4;
    localparam int FS    = 3;
    localparam int SS    = 2;
    localparam int HC    = 5;
    localparam int TOTAL = FS + SS;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] i_req;
    logic [3:0] i_rand;
    logic       o_step;
    logic [1:0] o_grant;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_result0;
    logic [3:0] o_result1;

    int checks = 0;
    int errors = 0;

    // Observations of the most recent roll.
    int   step_cyc[$];
    int   done_cyc[$];
    int   idle_cyc;
    logic grant_changed;
    logic [3:0] last_rand;

    // Reference model.
    int         exp_step[TOTAL];
    int         exp_done;
    int         exp_idle;
    logic       rr_ptr;
    logic [1:0] pend;
    logic [1:0] exp_grant;
    logic [3:0] exp_res0;
    logic [3:0] exp_res1;

    always #5 clk = ~clk;

    dice_roll_scheduler #(
        .TICK_DIV   (TD),
        .FAST_STEPS (FS),
        .SLOW_STEPS (SS),
        .HOLD_CYCLES(HC)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (i_req),
        .i_rand   (i_rand),
        .o_step   (o_step),
        .o_grant  (o_grant),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result0(o_result0),
        .o_result1(o_result1)
    );

    function automatic logic [1:0] pick(input logic [1:0] req);
        if (req == 2'b11) return rr_ptr ? 2'b10 : 2'b01;
        return req;
    endfunction

    function automatic bit timing_ok();
        if (step_cyc.size() != TOTAL || done_cyc.size() != 1) return 0;
        foreach (exp_step[i]) if (step_cyc[i] != exp_step[i]) return 0;
        return (done_cyc[0] == exp_done) && (idle_cyc == exp_idle) && !grant_changed;
    endfunction

    // Called on an idle cycle's negedge; returns on the negedge of the first roll cycle.
    task automatic start_roll(input logic [1:0] req);
        logic [1:0] src;
        src       = (pend != 2'b00) ? pend : req;
        exp_grant = pick(src);
        rr_ptr    = (exp_grant == 2'b01);
`ifdef DICE_QUEUE_EN
        pend = (pend | req) & ~exp_grant;
`endif
        i_req = req;
        @(negedge clk);
    endtask

    task automatic watch_roll(input int inj_cyc, input logic [1:0] inj_req,
                              input logic use_fixed, input logic [3:0] fixed_val);
        step_cyc.delete();
        done_cyc.delete();
        idle_cyc      = -1;
        grant_changed = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            i_req = (cyc == inj_cyc) ? inj_req : 2'b00;
            if (!o_busy) begin
                idle_cyc = cyc;
                i_req    = 2'b00;
                break;
            end
`ifdef DICE_QUEUE_EN
            if (cyc == inj_cyc) pend = pend | (inj_req & ~exp_grant);
`endif
            if (o_grant !== exp_grant) grant_changed = 1'b1;
            if (o_done) done_cyc.push_back(cyc);
            if (o_step) begin
                step_cyc.push_back(cyc);
                i_rand    = (use_fixed && step_cyc.size() == TOTAL) ? fixed_val : 4'($urandom);
                last_rand = i_rand;
            end
            @(negedge clk);
        end
        if (exp_grant == 2'b01) exp_res0 = last_rand;
        else exp_res1 = last_rand;
    endtask

    task automatic drain_pending();
        while (pend != 2'b00) begin
            start_roll(2'b00);
            watch_roll(0, 2'b00, 1'b0, 4'h0);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        i_req  = 2'b00;
        i_rand = 4'h0;
        rr_ptr = 1'b0;
        pend   = 2'b00;
        exp_res0 = 4'h0;
        exp_res1 = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_step, o_grant, o_busy, o_done, o_result0, o_result1} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold outputs=%b required=0",
                     {o_step, o_grant, o_busy, o_done, o_result0, o_result1});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_grant, o_busy, o_done} !== 4'd0) begin
            errors++;
            $display("FAIL reset_release grant=%b busy=%b done=%b required 00/0/0",
                     o_grant, o_busy, o_done);
        end
    endtask

    task automatic test_single();
        start_roll(2'b01);
        checks++;
        if ({o_busy, o_grant} !== 3'b101) begin
            errors++;
            $display("FAIL single_grant busy=%b grant=%b required 1/01", o_busy, o_grant);
        end
        watch_roll(0, 2'b00, 1'b0, 4'h0);
        checks++;
        if (!timing_ok()) begin
            errors++;
            $display("FAIL single_timing steps=%p done=%p idle=%0d gchg=%b required steps=%p done=%0d idle=%0d",
                     step_cyc, done_cyc, idle_cyc, grant_changed, exp_step, exp_done, exp_idle);
        end
        checks++;
        if (o_result0 !== exp_res0) begin
            errors++;
            $display("FAIL single_result result0=%h required=%h", o_result0, exp_res0);
        end
        drain_pending();
    endtask

    task automatic test_simultaneous();
        for (int n = 0; n < 2; n++) begin
            start_roll(2'b11);
            checks++;
            if (o_grant !== exp_grant) begin
                errors++;
                $display("FAIL simul_grant%0d grant=%b required=%b", n, o_grant, exp_grant);
            end
            watch_roll(0, 2'b00, 1'b0, 4'h0);
            checks++;
            if ({o_result1, o_result0} !== {exp_res1, exp_res0}) begin
                errors++;
                $display("FAIL simul_result%0d results=%h/%h required=%h/%h",
                         n, o_result1, o_result0, exp_res1, exp_res0);
            end
            drain_pending();
        end
    endtask

    task automatic test_owner_rereq();
        start_roll(2'b01);
        watch_roll(7, 2'b01, 1'b0, 4'h0);
        checks++;
        if (!timing_ok()) begin
            errors++;
            $display("FAIL owner_rereq_timing steps=%p done=%p idle=%0d required steps=%p done=%0d idle=%0d",
                     step_cyc, done_cyc, idle_cyc, exp_step, exp_done, exp_idle);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL owner_rereq_restart busy=%b required=0", o_busy);
        end
    endtask

    task automatic test_nonowner();
        logic [3:0] res1_before;
        res1_before = o_result1;
        start_roll(2'b01);
        watch_roll(10, 2'b10, 1'b0, 4'h0);
        checks++;
        if (!timing_ok()) begin
            errors++;
            $display("FAIL nonowner_timing steps=%p done=%p idle=%0d required steps=%p done=%0d idle=%0d",
                     step_cyc, done_cyc, idle_cyc, exp_step, exp_done, exp_idle);
        end
`ifdef DICE_QUEUE_EN
        start_roll(2'b00);
        checks++;
        if (o_grant !== 2'b10) begin
            errors++;
            $display("FAIL nonowner_queued grant=%b required=10", o_grant);
        end
        watch_roll(0, 2'b00, 1'b0, 4'h0);
        checks++;
        if (o_result1 !== exp_res1) begin
            errors++;
            $display("FAIL nonowner_result1 result1=%h required=%h", o_result1, exp_res1);
        end
`else
        repeat (5) @(negedge clk);
        checks++;
        if ({o_busy, o_result1} !== {1'b0, res1_before}) begin
            errors++;
            $display("FAIL nonowner_dropped busy=%b result1=%h required 0/%h",
                     o_busy, o_result1, res1_before);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int done_seen;
        int busy_seen;
        start_roll(2'b01);
        for (int cyc = 1; cyc < 11; cyc++) begin
            i_req = (cyc == 3) ? 2'b10 : 2'b00;
            @(negedge clk);
        end
        i_req = 2'b00;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_live busy=%b required=1", o_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({o_step, o_grant, o_busy, o_done, o_result0, o_result1} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_async outputs=%b required=0",
                     {o_step, o_grant, o_busy, o_done, o_result0, o_result1});
        end
        @(negedge clk);
        rst      = 1'b0;
        rr_ptr   = 1'b0;
        pend     = 2'b00;
        exp_res0 = 4'h0;
        exp_res1 = 4'h0;
        done_seen = 0;
        busy_seen = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (o_done) done_seen++;
            if (o_busy) busy_seen++;
        end
        checks++;
        if (done_seen != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet done_cycles=%0d busy_cycles=%0d required 0/0",
                     done_seen, busy_seen);
        end
    endtask

    task automatic test_result_retain();
        start_roll(2'b10);
        watch_roll(0, 2'b00, 1'b0, 4'h0);
        drain_pending();
        start_roll(2'b01);
        watch_roll(0, 2'b00, 1'b1, 4'hA);
        checks++;
        if ({o_result0, o_result1} !== {4'hA, exp_res1}) begin
            errors++;
            $display("FAIL result_retain result0=%h result1=%h required A/%h",
                     o_result0, o_result1, exp_res1);
        end
        drain_pending();
    endtask

    task automatic test_random();
        logic [1:0] r;
        for (int n = 0; n < 6; n++) begin
            r = 2'($urandom_range(1, 3));
            start_roll(r);
            checks++;
            if (o_grant !== exp_grant) begin
                errors++;
                $display("FAIL random%0d_grant req=%b grant=%b required=%b", n, r, o_grant, exp_grant);
            end
            watch_roll(0, 2'b00, 1'b0, 4'h0);
            checks++;
            if (!timing_ok() || {o_result1, o_result0} !== {exp_res1, exp_res0}) begin
                errors++;
                $display("FAIL random%0d_roll steps=%p idle=%0d results=%h/%h required steps=%p idle=%0d results=%h/%h",
                         n, step_cyc, idle_cyc, o_result1, o_result0, exp_step, exp_idle,
                         exp_res1, exp_res0);
            end
            drain_pending();
        end
    endtask

    initial begin
        int t;
        t = 1;
        for (int k = 1; k <= TOTAL; k++) begin
            t += (k <= FS) ? TD : (TD << (k - FS));
            exp_step[k-1] = t;
        end
        exp_done = t + 1;
        exp_idle = exp_done + HC + 1;

        test_reset();
        test_single();
        test_simultaneous();
        test_owner_rereq();
        test_nonowner();
        test_reset_mid();
        test_result_retain();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
